// File: rtl/compare_pkg.sv
// compare_pkg
//   Shared types and helpers for the compare_tracker slice.
//   rel_t        : 2-bit relation code (NONE=00, LT=01, EQ=10, GT=11).
//   flags_to_rel : packs one-hot lt/eq/gt flags into a rel_t.
package compare_pkg;

    typedef enum logic [1:0] {
        REL_NONE = 2'b00,
        REL_LT   = 2'b01,
        REL_EQ   = 2'b10,
        REL_GT   = 2'b11
    } rel_t;

    // All-zero flags, as seen straight out of reset, map to REL_NONE.
    function automatic rel_t flags_to_rel(input logic lt, input logic eq, input logic gt);
        rel_t r;
        r = REL_NONE;
        if (lt)
            r = REL_LT;
        else if (eq)
            r = REL_EQ;
        else if (gt)
            r = REL_GT;
        return r;
    endfunction

endpackage

// File: rtl/compare_tracker_rel_debounce.sv
// rel_debounce
//   Debounces a stream of relation samples. The stable relation only moves
//   to a new value after PERSIST consecutive valid samples agree on it.
//   Idle cycles (sample_valid=0) hold all state, so gaps do not break a run.
// Ports:
//   clk            : clock, rising edge
//   reset_n        : synchronous active-low reset
//   sample_valid   : sample_rel is meaningful this cycle
//   sample_rel     : relation sample
//   clear          : synchronous flush; wins over a same-cycle sample
//   stable_rel     : debounced relation (REL_NONE after reset/clear)
//   stable_changed : one-cycle pulse when stable_rel takes a new value
module rel_debounce
    import compare_pkg::*;
#(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_valid,
    input  rel_t sample_rel,
    input  logic clear,
    output rel_t stable_rel,
    output logic stable_changed
);

    localparam int CNT_W = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
    // cnt value that, once matched again, completes a run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);

    rel_t             cand;
    rel_t             cand_nxt;
    rel_t             stable_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             changed_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_rel     <= REL_NONE;
            cand           <= REL_NONE;
            cnt            <= '0;
            stable_changed <= 1'b0;
        end else begin
            stable_rel     <= stable_nxt;
            cand           <= cand_nxt;
            cnt            <= cnt_nxt;
            stable_changed <= changed_nxt;
        end
    end

    // cand/cnt describe the run in progress of a relation that differs from
    // stable_rel. A sample matching stable_rel, or a different relation,
    // abandons that run.
    always_comb begin
        stable_nxt  = stable_rel;
        cand_nxt    = cand;
        cnt_nxt     = cnt;
        changed_nxt = 1'b0;

        if (clear) begin
            stable_nxt = REL_NONE;
            cand_nxt   = REL_NONE;
            cnt_nxt    = '0;
        end else if (sample_valid) begin
            if (sample_rel == stable_rel) begin
                cand_nxt = REL_NONE;
                cnt_nxt  = '0;
            end else if (sample_rel == cand) begin
                if (cnt == CNT_LAST) begin
                    stable_nxt  = sample_rel;
                    cand_nxt    = REL_NONE;
                    cnt_nxt     = '0;
                    changed_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (PERSIST == 1) begin
                // A single disagreeing sample is already a full run.
                stable_nxt  = sample_rel;
                cand_nxt    = REL_NONE;
                cnt_nxt     = '0;
                changed_nxt = 1'b1;
            end else begin
                cand_nxt = sample_rel;
                cnt_nxt  = CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/compare_tracker.sv
// compare_tracker
//   Registered magnitude comparator (unsigned or two's complement) followed
//   by a relation debouncer that filters out single-sample glitches.
// Ports:
//   clk            : clock, rising edge
//   reset_n        : synchronous active-low reset
//   in_valid       : a, b and signed_mode are sampled this cycle
//   a, b           : WIDTH-bit operands
//   signed_mode    : 1 = two's-complement compare, 0 = unsigned
//   clear          : flushes the debouncer only; compare stage unaffected
//   out_valid      : lt/eq/gt were loaded on the previous edge
//   lt, eq, gt     : registered a<b, a==b, a>b (hold when no new sample)
//   stable_rel     : debounced relation, NONE=00 LT=01 EQ=10 GT=11
//   stable_changed : one-cycle pulse when stable_rel changes
module compare_tracker
    import compare_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [1:0]       stable_rel,
    output logic             stable_changed
);

    logic lt_c;
    logic eq_c;
    logic gt_c;
    rel_t stage1_rel;
    rel_t stable_rel_q;

    always_comb begin
        lt_c = 1'b0;
        gt_c = 1'b0;
        if (signed_mode) begin
            lt_c = $signed(a) < $signed(b);
            gt_c = $signed(a) > $signed(b);
        end else begin
            lt_c = a < b;
            gt_c = a > b;
        end
    end

    assign eq_c = (a == b);

    // Flags keep their last value on idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                lt <= lt_c;
                eq <= eq_c;
                gt <= gt_c;
            end
        end
    end

    assign stage1_rel = flags_to_rel(lt, eq, gt);

    rel_debounce #(
        .PERSIST(PERSIST)
    ) u_debounce (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_valid  (out_valid),
        .sample_rel    (stage1_rel),
        .clear         (clear),
        .stable_rel    (stable_rel_q),
        .stable_changed(stable_changed)
    );

    assign stable_rel = stable_rel_q;

endmodule

// File: tb/tb_compare_tracker.sv
// tb_compare_tracker
//   Drives two compare_tracker instances (WIDTH=8/PERSIST=4 and
//   WIDTH=16/PERSIST=1) through directed scenarios and a randomized run.
//   Expected values come from a reference model that evaluates the
//   comparison arithmetically and debounces by inspecting a window of the
//   most recent samples.
module tb_compare_tracker;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        in_valid [2];
    logic [15:0] a_in     [2];
    logic [15:0] b_in     [2];
    logic        sm       [2];

    logic       ov_a, lt_a, eq_a, gt_a, chg_a;
    logic [1:0] srel_a;
    logic       ov_b, lt_b, eq_b, gt_b, chg_b;
    logic [1:0] srel_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = DUT A, 1 = DUT B.
    int persist_of [2] = '{4, 1};
    int width_of   [2] = '{8, 16};
    int exp_ov     [2];
    int exp_rel    [2];
    int exp_stable [2];
    int exp_chg    [2];
    int win        [2][4];
    int wlen       [2];

    compare_tracker #(.WIDTH(8), .PERSIST(4)) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid[0]),
        .a             (a_in[0][7:0]),
        .b             (b_in[0][7:0]),
        .signed_mode   (sm[0]),
        .clear         (clear),
        .out_valid     (ov_a),
        .lt            (lt_a),
        .eq            (eq_a),
        .gt            (gt_a),
        .stable_rel    (srel_a),
        .stable_changed(chg_a)
    );

    compare_tracker #(.WIDTH(16), .PERSIST(1)) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid[1]),
        .a             (a_in[1]),
        .b             (b_in[1]),
        .signed_mode   (sm[1]),
        .clear         (clear),
        .out_valid     (ov_b),
        .lt            (lt_b),
        .eq            (eq_b),
        .gt            (gt_b),
        .stable_rel    (srel_b),
        .stable_changed(chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Relation of the currently driven operands: 1=LT 2=EQ 3=GT.
    function automatic int refRel(input int d);
        longint span;
        longint x;
        longint y;
        span = longint'(1) << width_of[d];
        x = longint'(a_in[d]) & (span - 1);
        y = longint'(b_in[d]) & (span - 1);
        if (sm[d]) begin
            if (x >= span / 2) x = x - span;
            if (y >= span / 2) y = y - span;
        end
        if (x < y) return 1;
        if (x == y) return 2;
        return 3;
    endfunction

    // Advances the model by one rising edge using the inputs being driven.
    task automatic modelEdge();
        bit same;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                exp_ov[d]     = 0;
                exp_rel[d]    = 0;
                exp_stable[d] = 0;
                exp_chg[d]    = 0;
                wlen[d]       = 0;
            end else begin
                exp_chg[d] = 0;
                if (clear) begin
                    exp_stable[d] = 0;
                    wlen[d]       = 0;
                end else if (exp_ov[d] != 0) begin
                    if (wlen[d] == persist_of[d]) begin
                        for (int k = 0; k < persist_of[d] - 1; k++)
                            win[d][k] = win[d][k+1];
                        win[d][persist_of[d]-1] = exp_rel[d];
                    end else begin
                        win[d][wlen[d]] = exp_rel[d];
                        wlen[d]++;
                    end
                    // Stable moves once the last PERSIST samples since the
                    // previous flush all name the same new relation.
                    if (wlen[d] == persist_of[d]) begin
                        same = 1'b1;
                        for (int k = 1; k < persist_of[d]; k++)
                            if (win[d][k] != win[d][0]) same = 1'b0;
                        if (same && win[d][0] != exp_stable[d]) begin
                            exp_stable[d] = win[d][0];
                            exp_chg[d]    = 1;
                            wlen[d]       = 0;
                        end
                    end
                end
                if (in_valid[d]) begin
                    exp_ov[d]  = 1;
                    exp_rel[d] = refRel(d);
                end else begin
                    exp_ov[d] = 0;
                end
            end
        end
    endtask

    task automatic checkDut(input int d, input logic ov, input logic lt, input logic eq,
                            input logic gt, input logic [1:0] srel, input logic chg);
        checkOutput($sformatf("d%0d_out_valid", d), 32'(ov), 32'(exp_ov[d]));
        checkOutput($sformatf("d%0d_lt", d), 32'(lt), 32'(exp_rel[d] == 1));
        checkOutput($sformatf("d%0d_eq", d), 32'(eq), 32'(exp_rel[d] == 2));
        checkOutput($sformatf("d%0d_gt", d), 32'(gt), 32'(exp_rel[d] == 3));
        checkOutput($sformatf("d%0d_stable_rel", d), 32'(srel), 32'(exp_stable[d]));
        checkOutput($sformatf("d%0d_stable_changed", d), 32'(chg), 32'(exp_chg[d]));
    endtask

    task automatic setOp(input int d, input bit v, input int av, input int bv, input bit s);
        in_valid[d] = v;
        a_in[d]     = 16'(av);
        b_in[d]     = 16'(bv);
        sm[d]       = s;
    endtask

    // One clock: model the edge, then compare away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkDut(0, ov_a, lt_a, eq_a, gt_a, srel_a, chg_a);
        checkDut(1, ov_b, lt_b, eq_b, gt_b, srel_b, chg_b);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus();
        applyStimulus();
        reset_n = 1'b1;
    endtask

    function automatic int pickVal(input int d);
        int half;
        half = 1 << (width_of[d] - 1);
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return half - 1;
            3:       return half;
            4:       return 2 * half - 1;
            default: return int'($urandom_range(0, 2 * half - 1));
        endcase
    endfunction

    initial begin
        clear = 1'b0;
        setOp(0, 1'b1, 'h12, 'h34, 1'b0);
        setOp(1, 1'b1, 'h1234, 'h0034, 1'b1);

        // Reset held for two cycles while in_valid is high.
        doReset();
        checkOutput("rst_out_valid", 32'(ov_a), 32'd0);
        checkOutput("rst_stable_rel", 32'(srel_a), 32'd0);
        checkOutput("rst_flags", 32'({lt_a, eq_a, gt_a}), 32'd0);
        setOp(1, 1'b0, 0, 0, 1'b0);

        // Signed / unsigned boundary operands.
        setOp(0, 1'b1, 'h80, 'h7F, 1'b0);
        applyStimulus();
        checkOutput("bnd_unsigned_gt", 32'(gt_a), 32'd1);
        setOp(0, 1'b1, 'h80, 'h7F, 1'b1);
        applyStimulus();
        checkOutput("bnd_signed_lt", 32'(lt_a), 32'd1);
        setOp(0, 1'b1, 'hA5, 'hA5, 1'b1);
        applyStimulus();
        checkOutput("bnd_signed_eq", 32'(eq_a), 32'd1);
        setOp(0, 1'b1, 'hA5, 'hA5, 1'b0);
        applyStimulus();
        checkOutput("bnd_unsigned_eq", 32'(eq_a), 32'd1);

        // Four agreeing GT samples.
        doReset();
        setOp(0, 1'b1, 5, 3, 1'b0);
        repeat (4) applyStimulus();
        checkOutput("deb_not_yet", 32'(srel_a), 32'd0);
        setOp(0, 1'b0, 5, 3, 1'b0);
        applyStimulus();
        checkOutput("deb_stable_gt", 32'(srel_a), 32'd3);
        checkOutput("deb_pulse", 32'(chg_a), 32'd1);
        applyStimulus();
        checkOutput("deb_pulse_once", 32'(chg_a), 32'd0);

        // Glitch: GT GT GT LT GT GT GT GT.
        doReset();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) setOp(0, 1'b1, 3, 5, 1'b0);
            else        setOp(0, 1'b1, 5, 3, 1'b0);
            applyStimulus();
        end
        checkOutput("glitch_hold", 32'(srel_a), 32'd0);
        setOp(0, 1'b0, 0, 0, 1'b0);
        applyStimulus();
        checkOutput("glitch_stable_gt", 32'(srel_a), 32'd3);

        // Gaps inside a run.
        doReset();
        setOp(0, 1'b1, 9, 2, 1'b0);
        repeat (2) applyStimulus();
        setOp(0, 1'b0, 9, 2, 1'b0);
        repeat (5) applyStimulus();
        checkOutput("gap_hold", 32'(srel_a), 32'd0);
        setOp(0, 1'b1, 9, 2, 1'b0);
        repeat (2) applyStimulus();
        setOp(0, 1'b0, 9, 2, 1'b0);
        applyStimulus();
        checkOutput("gap_stable_gt", 32'(srel_a), 32'd3);

        // Clear lands with the fourth LT reaching the tracker.
        setOp(0, 1'b1, 3, 5, 1'b0);
        repeat (4) applyStimulus();
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        checkOutput("clr_stable_none", 32'(srel_a), 32'd0);
        checkOutput("clr_no_pulse", 32'(chg_a), 32'd0);
        repeat (3) applyStimulus();
        setOp(0, 1'b0, 3, 5, 1'b0);
        applyStimulus();
        checkOutput("clr_stable_lt", 32'(srel_a), 32'd1);
        checkOutput("clr_pulse", 32'(chg_a), 32'd1);

        // PERSIST=1, WIDTH=16: alternating relation every cycle.
        doReset();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) setOp(1, 1'b1, 'h9000, 'h1000, 1'b0);
            else            setOp(1, 1'b1, 'h1000, 'h9000, 1'b0);
            applyStimulus();
            if (i >= 1) begin
                checkOutput("p1_toggle_rel", 32'(srel_b), (i % 2 == 1) ? 32'd3 : 32'd1);
                checkOutput("p1_toggle_pulse", 32'(chg_b), 32'd1);
            end
        end
        setOp(1, 1'b0, 0, 0, 1'b0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 1500; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            clear   = ($urandom_range(0, 29) == 0);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0)
                    setOp(d, ($urandom_range(0, 3) != 0), pickVal(d), pickVal(d),
                          1'($urandom_range(0, 1)));
                else
                    in_valid[d] = ($urandom_range(0, 3) != 0);
            end
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compare_tracker.md
# compare_tracker

Registered, parametrised successor to the combinational magnitude comparator. It compares two WIDTH-bit operands in unsigned or two's-complement mode and registers the lt/eq/gt flags. It also keeps a debounced "stable relation" that changes only after PERSIST consecutive valid samples agree on a new relation. It sits between sampled data sources (ADC, counters, sensor paths) and control logic that must not react to single-sample glitches.

## Interface
- WIDTH, 8, operand width in bits, ≥1
- PERSIST, 4, consecutive agreeing valid samples needed to change the stable relation, ≥1
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  a/b/signed_mode are sampled this cycle
- a  in  WIDTH  left operand
- b  in  WIDTH  right operand
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with in_valid
- clear  in  1  synchronous tracker flush; does not affect the stage-1 outputs
- out_valid  out  1  registered lt/eq/gt are valid
- lt, eq, gt  out  1 each  registered a<b, a==b, a>b; exactly one high when out_valid
- stable_rel  out  2  debounced relation: NONE=00, LT=01, EQ=10, GT=11
- stable_changed  out  1  one-cycle pulse when stable_rel takes a new value

## Operation
- Stage 1 (compare): on in_valid, compute the relation with $signed or unsigned comparison per signed_mode. Register lt/eq/gt and set out_valid=1. Without in_valid, out_valid=0 and lt/eq/gt hold their last values.
- Stage 2 (tracker) acts on each out_valid sample r. State: stable_rel, cand (2 bits), cnt (width $clog2(PERSIST+1)).
  - r == stable_rel: cand←NONE, cnt←0.
  - r ≠ stable_rel, r == cand: if cnt+1 == PERSIST then stable_rel←r, cand←NONE, cnt←0, stable_changed←1; else cnt←cnt+1.
  - r ≠ stable_rel, r ≠ cand: cand←r, cnt←1. If PERSIST==1, stable_rel←r immediately and stable_changed←1; cand and cnt stay at NONE/0.
- Cycles without out_valid: tracker holds. Gaps do not break a run.
- clear: stable_rel←NONE, cand←NONE, cnt←0, stable_changed←0. clear has priority over a same-cycle out_valid sample; that sample is discarded by the tracker.
- The first PERSIST agreeing samples after reset or clear move stable_rel from NONE to the relation. This transition pulses stable_changed.
- cnt never exceeds PERSIST−1 at rest; no wrap is possible.

## Timing
- Reset (reset_n=0 at a clk edge): out_valid=0, lt=0, eq=0, gt=0, stable_rel=NONE, stable_changed=0, cand=NONE, cnt=0. Reset applied mid-run discards all partial runs.
- Latency: sample at edge t gives lt/eq/gt/out_valid at t+1. A qualifying stable_rel update and stable_changed appear at t+2.
- Throughput: one sample per cycle; no back-pressure.
- stable_changed is high for exactly one cycle per transition. Consecutive transitions pulse on consecutive cycles only when PERSIST==1.
- Boundary operands:
  - signed, WIDTH=8: 0x80 < 0x7F
  - unsigned, WIDTH=8: 0x80 > 0x7F
  - a==b gives eq in both modes

## Structure
- Package compare_pkg holds:
  - rel_t, a 2-bit enum (REL_NONE, REL_LT, REL_EQ, REL_GT)
  - a function that converts lt/eq/gt flags to rel_t
- Sub-module rel_debounce (parameter PERSIST) implements stage 2, taking rel_t samples plus valid/clear. The top level instantiates it after the stage-1 register.
- Expected size is about 150–250 lines total.

## Test plan
- Reset with WIDTH=8, PERSIST=4, reset_n low for 2 cycles with in_valid=1 → all outputs 0, stable_rel=NONE throughout.
- Signed/unsigned boundary: a=0x80, b=0x7F, signed_mode=0 then 1 → gt=1 then lt=1, each one cycle after its sample.
- Debounce: 4 consecutive valid samples with a=5, b=3 → stable_rel=GT and stable_changed=1 exactly at the cycle after the 4th stage-1 output. A glitch pattern GT,GT,GT,LT,GT → no change from NONE until 4 further GTs.
- Gaps: 2 GT samples, 5 idle cycles, 2 GT samples → stable_rel=GT after the 4th sample; cnt held during the gap.
- clear mid-run: stable=GT, 3 LT samples, clear coincident with the 4th LT → stable_rel=NONE, no stable_changed pulse. The next 4 LT samples give LT.
- PERSIST=1, WIDTH=16: alternating a>b / a<b every cycle → stable_rel toggles GT/LT each cycle, with stable_changed high continuously.
